eadd_pipe: RTL
==============

EADD_PIPE -- requirements
Module: eadd_pipe

Interface
REQ-001 SHALL have parameter LANES, default 4: number of bf16 lanes per beat.
REQ-002 SHALL have parameter ADD_LAT, default 11: fixed latency of each floating_add core, in cycles.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: result FIFO entries; must be at least ADD_LAT+2.
REQ-004 SHALL have parameter CNT_W, default 16: width of the beat counter.
REQ-005 SHALL have port clk  in  1: the single clock for the block.
REQ-006 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-007 SHALL have port stage_start  in  1: a rising edge starts a job.
REQ-008 SHALL have port mode  in  1: 0 selects a+b, 1 selects a-b; sampled at job start.
REQ-009 SHALL have port len  in  CNT_W: job length in beats; sampled at job start.
REQ-010 SHALL have ports a_tvalid in 1, a_tready out 1 and a_tdata in 16*LANES: operand A stream.
REQ-011 SHALL have ports b_tvalid in 1, b_tready out 1 and b_tdata in 16*LANES: operand B stream.
REQ-012 SHALL have ports result_tvalid out 1, result_tready in 1, result_tdata out 32*LANES and result_tlast out 1: result stream.
REQ-013 SHALL have port busy  out 1: high whenever the state is not IDLE.
REQ-014 SHALL have port done  out 1: one-cycle pulse at job completion.

Function
REQ-015 SHALL use three FSM states: IDLE, RUN and DRAIN.
REQ-016 In IDLE, a stage_start rising edge (stage_start high with the previous-cycle stage_start low) SHALL latch mode and len, clear the counters, and move to RUN; if len==0 it SHALL instead stay in IDLE and pulse done on the next cycle.
REQ-017 SHALL ignore stage_start edges while in RUN or DRAIN.
REQ-018 SHALL drive a_tready = b_tready = (state==RUN) && (issued<len) && (inflight+fifo_count < FIFO_DEPTH); tready SHALL NOT depend on either tvalid.
REQ-019 SHALL accept a beat only when a_tvalid, b_tvalid and tready are all high in the same cycle; one input valid alone SHALL NOT be consumed.
REQ-020 SHALL map lane i to a_tdata/b_tdata[16i+15:16i] and to result_tdata[32i+31:32i].
REQ-021 SHALL extend each bf16 lane operand to fp32 as {bf16,16'h0000}; in mode 1 it SHALL invert bit 15 of each B lane before extension.
REQ-022 SHALL write an accepted beat's results into the FIFO exactly ADD_LAT cycles after acceptance, timed by an internal ADD_LAT-deep valid shift register; the core tvalid outputs SHALL be unused.
REQ-023 SHALL set result_tlast on the len-th result of the job and on no other result.
REQ-024 SHALL move from RUN to DRAIN in the cycle after issued reaches len.
REQ-025 SHALL return from DRAIN to IDLE and pulse done in the cycle after the tlast beat handshakes on the result port.
REQ-026 SHALL present the FIFO as first-word-fall-through: result_tvalid = !empty, and a pop occurs on result_tvalid && result_tready.
REQ-027 SHALL make the FIFO never overflow; a simultaneous push and pop at full SHALL be legal and leave the count unchanged.
REQ-028 SHALL give a minimum latency of ADD_LAT+1 cycles from input acceptance to result_tvalid.
REQ-029 SHALL sustain one beat per cycle when result_tready is held high.

Reset
REQ-030 While rst_n is low, the block SHALL force state IDLE, all counters 0, the valid shift register cleared, the FIFO empty, and the latched mode and len to 0.
REQ-031 While rst_n is low, the block SHALL drive all outputs to 0: a_tready, b_tready, result_tvalid, result_tlast, busy, done and result_tdata.
REQ-032 A reset mid-job SHALL discard all in-flight and buffered results, and no result_tvalid SHALL appear after reset is released.

Structure
REQ-033 Package eadd_pkg SHALL hold the state enum, BF16_W=16, FP32_W=32, and the default parameter values.
REQ-034 SHALL contain one sub-module, eadd_res_fifo: a parametrised synchronous FWFT FIFO with count output and the asynchronous active-low reset.
REQ-035 SHALL instantiate LANES floating_add cores through a generate loop, with no reset on the cores.

Verification
REQ-036 Add test: LANES=4, mode=0, len=1, every A lane 0x3F80 and every B lane 0x4000 -> every result lane 0x40400000, tlast=1, and done one cycle after the handshake.
REQ-037 Subtract test: mode=1 with the same operands as REQ-036 -> every result lane 0xBF800000.
REQ-038 Backpressure test: len=40, result_tready low for 30 cycles -> tready falls once inflight+count reaches 16, all 40 results arrive in order, and tlast is set only on result 40.
REQ-039 Join test: a_tvalid high and b_tvalid low for 5 cycles, then both high -> exactly one beat is accepted, and only after b_tvalid rises.
REQ-040 len=0 and retrigger test: a len=0 start -> done pulses and busy stays 0; a stage_start pulse during RUN -> len, mode and the counters are unchanged.
REQ-041 Reset test: assert rst_n low for 2 cycles during a len=10 job with 3 beats in flight -> all outputs 0, and no result_tvalid for 20 cycles after release.

Source files
------------

// File: rtl/eadd_pkg.sv
// Shared types and defaults for the bf16 lane-parallel add/subtract pipeline.
package eadd_pkg;

    localparam int BF16_W         = 16;
    localparam int FP32_W         = 32;
    localparam int DEF_LANES      = 4;
    localparam int DEF_ADD_LAT    = 11;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // bf16 is the upper half of fp32, so widening is exact.
    function automatic logic [FP32_W-1:0] bf16_to_fp32(input logic [BF16_W-1:0] h);
        return {h, 16'h0000};
    endfunction

endpackage

// File: rtl/eadd_if.sv
// Operand A/B input streams and the result stream of eadd_pipe.
// valid/ready: a beat moves on a rising clk edge where tvalid and tready are both high; ready never waits on valid.
interface eadd_if import eadd_pkg::*; #(
    parameter int LANES = DEF_LANES
);
    logic                      a_tvalid;
    logic                      a_tready;
    logic [BF16_W*LANES-1:0]   a_tdata;
    logic                      b_tvalid;
    logic                      b_tready;
    logic [BF16_W*LANES-1:0]   b_tdata;
    logic                      result_tvalid;
    logic                      result_tready;
    logic [FP32_W*LANES-1:0]   result_tdata;
    logic                      result_tlast;

    modport master (
        output a_tvalid, a_tdata, b_tvalid, b_tdata, result_tready,
        input  a_tready, b_tready, result_tvalid, result_tdata, result_tlast
    );

    modport slave (
        input  a_tvalid, a_tdata, b_tvalid, b_tdata, result_tready,
        output a_tready, b_tready, result_tvalid, result_tdata, result_tlast
    );

endinterface

// File: rtl/eadd_res_fifo.sv
// First-word-fall-through result FIFO with occupancy count; output data reads 0 while empty.
module eadd_res_fifo #(
    parameter int W     = 129,
    parameter int DEPTH = 16,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr_en, rd_en;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_en = pop && (count != '0);
    // Pushing into a full FIFO is fine when the same cycle pops.
    assign wr_en = push && ((count < CW'(DEPTH)) || rd_en);
    assign empty = (count == '0);
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/floating_add.sv
// Fixed-latency fp32 adder core (normal numbers, truncating, flush-to-zero); no reset on the pipeline.
module floating_add #(
    parameter int LAT = 11
) (
    input  logic        aclk,
    input  logic        s_axis_a_tvalid,
    input  logic [31:0] s_axis_a_tdata,
    input  logic        s_axis_b_tvalid,
    input  logic [31:0] s_axis_b_tdata,
    output logic        m_axis_result_tvalid,
    output logic [31:0] m_axis_result_tdata
);

    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] big, sml;
        logic [7:0]  d;
        logic [26:0] mb, ms, m;
        logic [9:0]  e;
        if (x[30:0] >= y[30:0]) begin big = x; sml = y; end
        else begin big = y; sml = x; end
        d  = big[30:23] - sml[30:23];
        mb = {1'b0, big[30:23] != 8'd0, big[22:0], 2'b00};
        ms = {1'b0, sml[30:23] != 8'd0, sml[22:0], 2'b00};
        ms = (d > 8'd26) ? 27'd0 : (ms >> d);
        e  = {2'b00, big[30:23]};
        m  = (big[31] == sml[31]) ? (mb + ms) : (mb - ms);
        if (m[26]) begin
            m = m >> 1;
            e = e + 10'd1;
        end else begin
            for (int i = 0; i < 25; i++) begin
                if (!m[25] && m != 27'd0) begin
                    m = m << 1;
                    e = e - 10'd1;
                end
            end
        end
        if (m == 27'd0 || e[9] || e == 10'd0) return {big[31] & sml[31], 31'd0};
        else if (e >= 10'd255)                return {big[31], 8'hFF, 23'd0};
        else                                  return {big[31], e[7:0], m[24:2]};
    endfunction

    logic [31:0]    dpipe [LAT];
    logic [LAT-1:0] vpipe;

    always_ff @(posedge aclk) begin
        dpipe[0] <= fp_add(s_axis_a_tdata, s_axis_b_tdata);
        vpipe[0] <= s_axis_a_tvalid && s_axis_b_tvalid;
        for (int k = 1; k < LAT; k++) begin
            dpipe[k] <= dpipe[k-1];
            vpipe[k] <= vpipe[k-1];
        end
    end

    assign m_axis_result_tdata  = dpipe[LAT-1];
    assign m_axis_result_tvalid = vpipe[LAT-1];

endmodule

// File: rtl/eadd_pipe.sv
// Job-based bf16 add/subtract: joins A and B streams, runs LANES fp32 adders, buffers results in a FIFO.
module eadd_pipe import eadd_pkg::*; #(
    parameter int LANES      = DEF_LANES,
    parameter int ADD_LAT    = DEF_ADD_LAT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stage_start,
    input  logic             mode,
    input  logic [CNT_W-1:0] len,
    eadd_if.slave            s,
    output logic             busy,
    output logic             done,
    output state_t           state_dbg
);

    localparam int FC_W = $clog2(FIFO_DEPTH + 1);

    state_t                  state, state_nx;
    logic                    start_d, start_edge, mode_q, done_q;
    logic [CNT_W-1:0]        len_q, issued;
    logic [FC_W-1:0]         inflight, fifo_count;
    logic [ADD_LAT-1:0]      vld_sr, last_sr;
    logic                    ready, accept, pop, last_pop, fifo_empty;
    logic [FP32_W*LANES-1:0] sum_data;
    logic [LANES-1:0]        core_tvalid_unused;

    assign start_edge = stage_start && !start_d;
    // Everything already issued is guaranteed a FIFO slot, so the FIFO cannot overflow.
    assign ready      = (state == RUN) && (issued < len_q) &&
                        (({1'b0, inflight} + {1'b0, fifo_count}) < (FC_W + 1)'(FIFO_DEPTH));
    assign accept     = ready && s.a_tvalid && s.b_tvalid;
    assign pop        = s.result_tvalid && s.result_tready;
    assign last_pop   = pop && s.result_tlast;

    assign s.a_tready = ready;
    assign s.b_tready = ready;
    assign busy       = (state != IDLE);
    assign done       = done_q;
    assign state_dbg  = state;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_edge && len != '0) state_nx = RUN;
            RUN:     if (issued == len_q)         state_nx = DRAIN;
            DRAIN:   if (last_pop)                state_nx = IDLE;
            default:                              state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            start_d  <= 1'b0;
            mode_q   <= 1'b0;
            len_q    <= '0;
            issued   <= '0;
            inflight <= '0;
            vld_sr   <= '0;
            last_sr  <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            start_d  <= stage_start;
            done_q   <= (state == IDLE && start_edge && len == '0) || (state == DRAIN && last_pop);
            vld_sr   <= {vld_sr[ADD_LAT-2:0], accept};
            last_sr  <= {last_sr[ADD_LAT-2:0], accept && (issued == len_q - 1'b1)};
            inflight <= inflight + FC_W'(accept) - FC_W'(vld_sr[ADD_LAT-1]);
            if (state == IDLE && start_edge) begin
                mode_q <= mode;
                len_q  <= len;
                issued <= '0;
            end else if (accept) begin
                issued <= issued + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [FP32_W-1:0] op_a, op_b;
        assign op_a = bf16_to_fp32(s.a_tdata[BF16_W*i +: BF16_W]);
        // Subtraction is addition of B with its sign flipped.
        assign op_b = bf16_to_fp32(s.b_tdata[BF16_W*i +: BF16_W] ^ {mode_q, 15'd0});

        floating_add #(.LAT(ADD_LAT)) u_add (
            .aclk                 (clk),
            .s_axis_a_tvalid      (accept),
            .s_axis_a_tdata       (op_a),
            .s_axis_b_tvalid      (accept),
            .s_axis_b_tdata       (op_b),
            .m_axis_result_tvalid (core_tvalid_unused[i]),
            .m_axis_result_tdata  (sum_data[FP32_W*i +: FP32_W])
        );
    end

    eadd_res_fifo #(.W(FP32_W*LANES + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (vld_sr[ADD_LAT-1]),
        .din   ({last_sr[ADD_LAT-1], sum_data}),
        .pop   (pop),
        .dout  ({s.result_tlast, s.result_tdata}),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign s.result_tvalid = !fifo_empty;

endmodule
